// File: rtl/dc_pfreq_rx_pkg.sv
// Shared types for the DC prefetch-request receiver (dc_pfreq_rx).
// Optional duplicate dropping is enabled by defining PFQ_DEDUP_EN.
`ifndef PF_STATBITS
`define PF_STATBITS 16
`endif

package dc_pfreq_rx_pkg;

  typedef logic [33:0] SC_laddr_type;
  typedef logic [21:0] SC_sptbr_type;

  typedef enum logic [1:0] {
    PF_LOOK_MISS     = 2'd0,
    PF_LOOK_HIT      = 2'd1,
    PF_LOOK_HITMISSD = 2'd2,
    PF_LOOK_HITMISSP = 2'd3
  } PF_lookres_type;

  typedef struct packed {
    SC_laddr_type laddr;
    SC_sptbr_type sptbr;
    logic         l2;
  } PF_dcreq_type;

endpackage

// File: rtl/pfreq_fifo.sv
// DEPTH-entry request FIFO for dc_pfreq_rx; with PFQ_DEDUP_EN defined it also
// exposes a per-entry match vector against a candidate laddr/sptbr.
module pfreq_fifo
  import dc_pfreq_rx_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  PF_dcreq_type wdata_i,
  output PF_dcreq_type rdata_o,
  output logic [AW:0]  count_o
`ifdef PFQ_DEDUP_EN
  ,
  input  SC_laddr_type     cmp_laddr_i,
  input  SC_sptbr_type     cmp_sptbr_i,
  output logic [DEPTH-1:0] match_o
`endif
);

  PF_dcreq_type  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef PFQ_DEDUP_EN
  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [AW-1:0] off;
    assign off        = AW'(i) - rd_ptr_q;
    assign match_o[i] = ({1'b0, off} < count_q)
                        && (mem_q[i].laddr == cmp_laddr_i)
                        && (mem_q[i].sptbr == cmp_sptbr_i);
  end
`endif

endmodule

// File: rtl/dc_pfreq_rx.sv
// DC-side prefetch request receiver: queues requests, issues tag lookups and
// keeps saturating statistics. Define PFQ_DEDUP_EN to drop duplicate requests.
`ifndef PF_STATBITS
`define PF_STATBITS 16
`endif

module dc_pfreq_rx
  import dc_pfreq_rx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int STATBITS = `PF_STATBITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pftodc_req_valid,
  output logic                pftodc_req_retry,
  input  SC_laddr_type        pftodc_req_laddr,
  input  SC_sptbr_type        pftodc_req_sptbr,
  input  logic                pftodc_req_l2,
  output logic                pfq_look_valid,
  input  logic                pfq_look_retry,
  output SC_laddr_type        pfq_look_laddr,
  output SC_sptbr_type        pfq_look_sptbr,
  output logic                pfq_look_l2,
  input  logic                look_res_valid,
  input  PF_lookres_type      look_res,
  input  logic                snoop_valid,
  input  logic                disp_valid,
  input  logic                stats_clear,
  output logic [STATBITS-1:0] dcstats_nhitmissd,
  output logic [STATBITS-1:0] dcstats_nhitmissp,
  output logic [STATBITS-1:0] dcstats_nhithit,
  output logic [STATBITS-1:0] dcstats_nmiss,
  output logic [STATBITS-1:0] dcstats_ndrop,
  output logic [STATBITS-1:0] dcstats_nreqs,
  output logic [STATBITS-1:0] dcstats_nsnoops,
  output logic [STATBITS-1:0] dcstats_ndisp
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [STATBITS-1:0] sat_inc(input logic [STATBITS-1:0] v,
                                                  input logic                en);
    if (en && (v != '1)) return v + STATBITS'(1);
    return v;
  endfunction

  logic [AW:0]  count;
  PF_dcreq_type head, wreq;
  logic         accept, push, pop, dup;

  assign pftodc_req_retry = (count == (AW+1)'(DEPTH));
  assign pfq_look_valid   = (count != '0);
  assign accept           = pftodc_req_valid && !pftodc_req_retry;
  assign pop              = pfq_look_valid && !pfq_look_retry;
  assign push             = accept && !dup;

  assign wreq.laddr = pftodc_req_laddr;
  assign wreq.sptbr = pftodc_req_sptbr;
  assign wreq.l2    = pftodc_req_l2;

  // Gate the head fields so stale storage never shows while the queue is empty.
  assign pfq_look_laddr = pfq_look_valid ? head.laddr : '0;
  assign pfq_look_sptbr = pfq_look_valid ? head.sptbr : '0;
  assign pfq_look_l2    = pfq_look_valid ? head.l2    : 1'b0;

`ifdef PFQ_DEDUP_EN
  logic [DEPTH-1:0] match;

  pfreq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wreq),
    .rdata_o     (head),
    .count_o     (count),
    .cmp_laddr_i (pftodc_req_laddr),
    .cmp_sptbr_i (pftodc_req_sptbr),
    .match_o     (match)
  );

  assign dup = |match;
`else
  pfreq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wreq),
    .rdata_o (head),
    .count_o (count)
  );

  assign dup = 1'b0;
`endif

  logic [STATBITS-1:0] nhitmissd_q, nhitmissd_d, nhitmissp_q, nhitmissp_d;
  logic [STATBITS-1:0] nhithit_q, nhithit_d, nmiss_q, nmiss_d;
  logic [STATBITS-1:0] nreqs_q, nreqs_d, nsnoops_q, nsnoops_d;
  logic [STATBITS-1:0] ndisp_q, ndisp_d;

  always_comb begin
    nmiss_d     = sat_inc(nmiss_q,     look_res_valid && (look_res == PF_LOOK_MISS));
    nhithit_d   = sat_inc(nhithit_q,   look_res_valid && (look_res == PF_LOOK_HIT));
    nhitmissd_d = sat_inc(nhitmissd_q, look_res_valid && (look_res == PF_LOOK_HITMISSD));
    nhitmissp_d = sat_inc(nhitmissp_q, look_res_valid && (look_res == PF_LOOK_HITMISSP));
    nreqs_d     = sat_inc(nreqs_q,     accept);
    nsnoops_d   = sat_inc(nsnoops_q,   snoop_valid);
    ndisp_d     = sat_inc(ndisp_q,     disp_valid);
    if (stats_clear) begin
      nmiss_d     = '0;
      nhithit_d   = '0;
      nhitmissd_d = '0;
      nhitmissp_d = '0;
      nreqs_d     = '0;
      nsnoops_d   = '0;
      ndisp_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmiss_q     <= '0;
      nhithit_q   <= '0;
      nhitmissd_q <= '0;
      nhitmissp_q <= '0;
      nreqs_q     <= '0;
      nsnoops_q   <= '0;
      ndisp_q     <= '0;
    end else begin
      nmiss_q     <= nmiss_d;
      nhithit_q   <= nhithit_d;
      nhitmissd_q <= nhitmissd_d;
      nhitmissp_q <= nhitmissp_d;
      nreqs_q     <= nreqs_d;
      nsnoops_q   <= nsnoops_d;
      ndisp_q     <= ndisp_d;
    end
  end

`ifdef PFQ_DEDUP_EN
  logic [STATBITS-1:0] ndrop_q, ndrop_d;

  assign ndrop_d = stats_clear ? '0 : sat_inc(ndrop_q, accept && dup);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ndrop_q <= '0;
    else       ndrop_q <= ndrop_d;
  end

  assign dcstats_ndrop = ndrop_q;
`else
  assign dcstats_ndrop = '0;
`endif

  assign dcstats_nhitmissd = nhitmissd_q;
  assign dcstats_nhitmissp = nhitmissp_q;
  assign dcstats_nhithit   = nhithit_q;
  assign dcstats_nmiss     = nmiss_q;
  assign dcstats_nreqs     = nreqs_q;
  assign dcstats_nsnoops   = nsnoops_q;
  assign dcstats_ndisp     = ndisp_q;

endmodule

// File: tb/tb_dc_pfreq_rx.sv
// Self-checking bench for dc_pfreq_rx against a queue-based reference model;
// expectations follow PFQ_DEDUP_EN when it is defined.
module tb_dc_pfreq_rx;
  import dc_pfreq_rx_pkg::*;

  localparam int DEPTH    = 4;
  localparam int STATBITS = 4;
  localparam int SATMAX   = (1 << STATBITS) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                pftodc_req_valid;
  logic                pftodc_req_retry;
  SC_laddr_type        pftodc_req_laddr;
  SC_sptbr_type        pftodc_req_sptbr;
  logic                pftodc_req_l2;
  logic                pfq_look_valid;
  logic                pfq_look_retry;
  SC_laddr_type        pfq_look_laddr;
  SC_sptbr_type        pfq_look_sptbr;
  logic                pfq_look_l2;
  logic                look_res_valid;
  PF_lookres_type      look_res;
  logic                snoop_valid;
  logic                disp_valid;
  logic                stats_clear;
  logic [STATBITS-1:0] dcstats_nhitmissd, dcstats_nhitmissp, dcstats_nhithit, dcstats_nmiss;
  logic [STATBITS-1:0] dcstats_ndrop, dcstats_nreqs, dcstats_nsnoops, dcstats_ndisp;

  dc_pfreq_rx #(.DEPTH(DEPTH), .STATBITS(STATBITS)) dut (
    .clk               (clk),
    .reset             (reset),
    .pftodc_req_valid  (pftodc_req_valid),
    .pftodc_req_retry  (pftodc_req_retry),
    .pftodc_req_laddr  (pftodc_req_laddr),
    .pftodc_req_sptbr  (pftodc_req_sptbr),
    .pftodc_req_l2     (pftodc_req_l2),
    .pfq_look_valid    (pfq_look_valid),
    .pfq_look_retry    (pfq_look_retry),
    .pfq_look_laddr    (pfq_look_laddr),
    .pfq_look_sptbr    (pfq_look_sptbr),
    .pfq_look_l2       (pfq_look_l2),
    .look_res_valid    (look_res_valid),
    .look_res          (look_res),
    .snoop_valid       (snoop_valid),
    .disp_valid        (disp_valid),
    .stats_clear       (stats_clear),
    .dcstats_nhitmissd (dcstats_nhitmissd),
    .dcstats_nhitmissp (dcstats_nhitmissp),
    .dcstats_nhithit   (dcstats_nhithit),
    .dcstats_nmiss     (dcstats_nmiss),
    .dcstats_ndrop     (dcstats_ndrop),
    .dcstats_nreqs     (dcstats_nreqs),
    .dcstats_nsnoops   (dcstats_nsnoops),
    .dcstats_ndisp     (dcstats_ndisp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int dut_issued;

  // Reference model state: queued requests plus plain integer counters.
  PF_dcreq_type m_q[$];
  int m_nreqs, m_ndrop, m_nmiss, m_nhithit, m_nhitmissd, m_nhitmissp, m_nsnoops, m_ndisp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input bit en);
    return (en && v < SATMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_nreqs = 0; m_ndrop = 0; m_nmiss = 0; m_nhithit = 0;
    m_nhitmissd = 0; m_nhitmissp = 0; m_nsnoops = 0; m_ndisp = 0;
  endtask

  task automatic check_model();
    bit ne;
    ne = (m_q.size() != 0);
    chk("retry",   pftodc_req_retry, 64'(m_q.size() == DEPTH));
    chk("lvalid",  pfq_look_valid,   64'(ne));
    chk("laddr",   pfq_look_laddr,   ne ? 64'(m_q[0].laddr) : 64'd0);
    chk("sptbr",   pfq_look_sptbr,   ne ? 64'(m_q[0].sptbr) : 64'd0);
    chk("l2",      pfq_look_l2,      ne ? 64'(m_q[0].l2)    : 64'd0);
    chk("nreqs",   dcstats_nreqs,     64'(m_nreqs));
    chk("ndrop",   dcstats_ndrop,     64'(m_ndrop));
    chk("nmiss",   dcstats_nmiss,     64'(m_nmiss));
    chk("nhithit", dcstats_nhithit,   64'(m_nhithit));
    chk("nhmissd", dcstats_nhitmissd, 64'(m_nhitmissd));
    chk("nhmissp", dcstats_nhitmissp, 64'(m_nhitmissp));
    chk("nsnoops", dcstats_nsnoops,   64'(m_nsnoops));
    chk("ndisp",   dcstats_ndisp,     64'(m_ndisp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_retry"}, pftodc_req_retry, 0);
    chk({tag, "_lvalid"}, pfq_look_valid, 0);
    chk({tag, "_laddr"}, pfq_look_laddr, 0);
    chk({tag, "_stats"}, {dcstats_nhitmissd, dcstats_nhitmissp, dcstats_nhithit, dcstats_nmiss,
                          dcstats_ndrop, dcstats_nreqs, dcstats_nsnoops, dcstats_ndisp}, 0);
  endtask

  // One clock: check DUT against model, drive inputs, advance model, take the edge.
  task automatic cyc(input bit v, input SC_laddr_type la, input SC_sptbr_type sp, input bit l2,
                     input bit lr, input bit rv, input logic [1:0] rs,
                     input bit sn, input bit dp, input bit clr);
    bit acc, pop, dupm, full, ne;
    PF_dcreq_type e;
    @(negedge clk);
    check_model();
    pftodc_req_valid = v; pftodc_req_laddr = la; pftodc_req_sptbr = sp; pftodc_req_l2 = l2;
    pfq_look_retry = lr; look_res_valid = rv; look_res = PF_lookres_type'(rs);
    snoop_valid = sn; disp_valid = dp; stats_clear = clr;
    if (pfq_look_valid && !lr) dut_issued++;
    full = (m_q.size() == DEPTH);
    ne   = (m_q.size() != 0);
    acc  = v && !full;
    pop  = ne && !lr;
    dupm = 1'b0;
`ifdef PFQ_DEDUP_EN
    foreach (m_q[i]) if (m_q[i].laddr == la && m_q[i].sptbr == sp) dupm = 1'b1;
`endif
    if (pop) void'(m_q.pop_front());
    if (acc && !dupm) begin
      e.laddr = la; e.sptbr = sp; e.l2 = l2;
      m_q.push_back(e);
    end
    if (clr) begin
      m_nreqs = 0; m_ndrop = 0; m_nmiss = 0; m_nhithit = 0;
      m_nhitmissd = 0; m_nhitmissp = 0; m_nsnoops = 0; m_ndisp = 0;
    end else begin
      m_nreqs     = sat(m_nreqs, acc);
      m_ndrop     = sat(m_ndrop, acc && dupm);
      m_nmiss     = sat(m_nmiss, rv && rs == 2'd0);
      m_nhithit   = sat(m_nhithit, rv && rs == 2'd1);
      m_nhitmissd = sat(m_nhitmissd, rv && rs == 2'd2);
      m_nhitmissp = sat(m_nhitmissp, rv && rs == 2'd3);
      m_nsnoops   = sat(m_nsnoops, sn);
      m_ndisp     = sat(m_ndisp, dp);
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit lr, input bit clr);
    cyc(0, '0, '0, 0, lr, 0, 2'd0, 0, 0, clr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    SC_laddr_type addrs [4];
    SC_laddr_type pool [5];
    reset = 1'b1;
    pftodc_req_valid = 0; pftodc_req_laddr = '0; pftodc_req_sptbr = '0; pftodc_req_l2 = 0;
    pfq_look_retry = 0; look_res_valid = 0; look_res = PF_LOOK_MISS;
    snoop_valid = 0; disp_valid = 0; stats_clear = 0;
    dut_issued = 0;
    model_reset();
    #1;
    check_zero("reset_state");
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;

    // Fill and drain with the lookup side stalled.
    idle(1, 1);
    for (int i = 0; i < 4; i++) addrs[i] = 34'h1000 + 34'(i * 64);
    for (int i = 0; i < 5; i++) begin
      cyc(1, (i < 4) ? addrs[i] : 34'h2000, 22'h5, i[0], 1, 0, 2'd0, 0, 0, 0);
      if (i == 3) begin #1; chk("fill_retry", pftodc_req_retry, 1); end
    end
    #1;
    chk("fill_nreqs", dcstats_nreqs, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_addr", pfq_look_laddr, 64'(addrs[i]));
      idle(0, 0);
    end
    #1;
    chk("drain_empty", pfq_look_valid, 0);

    // Empty-queue latency.
    #1;
    chk("lat_before", pfq_look_valid, 0);
    cyc(1, 34'h40, 22'h1, 0, 1, 0, 2'd0, 0, 0, 0);
    #1;
    chk("lat_valid", pfq_look_valid, 1);
    chk("lat_addr", pfq_look_laddr, 34'h40);
    idle(0, 0);

    // Duplicate requests.
    idle(1, 1);
    dut_issued = 0;
    cyc(1, 34'h80, 22'h7, 0, 1, 0, 2'd0, 0, 0, 0);
    cyc(1, 34'h80, 22'h7, 1, 1, 0, 2'd0, 0, 0, 0);
    repeat (3) idle(0, 0);
    #1;
    chk("dedup_nreqs", dcstats_nreqs, 2);
`ifdef PFQ_DEDUP_EN
    chk("dedup_ndrop", dcstats_ndrop, 1);
    chk("dedup_issued", dut_issued, 1);
`else
    chk("dedup_ndrop", dcstats_ndrop, 0);
    chk("dedup_issued", dut_issued, 2);
`endif

    // Outcome counting.
    idle(0, 1);
    cyc(0, '0, '0, 0, 0, 1, 2'd0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 2'd1, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 2'd2, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 2'd3, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1, 2'd3, 1, 1, 0);
    #1;
    chk("out_nmiss", dcstats_nmiss, 1);
    chk("out_nhithit", dcstats_nhithit, 1);
    chk("out_nhitmissd", dcstats_nhitmissd, 1);
    chk("out_nhitmissp", dcstats_nhitmissp, 2);
    chk("out_nsnoops", dcstats_nsnoops, 1);
    chk("out_ndisp", dcstats_ndisp, 1);

    // Saturation, then clear winning over a same-cycle miss.
    idle(0, 1);
    repeat (20) cyc(0, '0, '0, 0, 0, 1, 2'd0, 0, 0, 0);
    #1;
    chk("sat_nmiss", dcstats_nmiss, 15);
    cyc(0, '0, '0, 0, 0, 1, 2'd0, 0, 0, 1);
    #1;
    chk("clr_nmiss", dcstats_nmiss, 0);

    // Asynchronous reset with entries queued.
    for (int i = 0; i < 3; i++) cyc(1, 34'h300 + 34'(i * 64), 22'h2, 0, 1, 1, 2'd1, 0, 0, 0);
    #2;
    pftodc_req_valid = 0; look_res_valid = 0; stats_clear = 0;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    dut_issued = 0;
    repeat (4) idle(0, 0);
    chk("midrst_issued", dut_issued, 0);

    // Randomized traffic with a small address pool so duplicates recur.
    pool[0] = 34'h40; pool[1] = 34'h80; pool[2] = 34'hC0; pool[3] = 34'h100; pool[4] = 34'h140;
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(99) < 60, pool[$urandom_range(4)], SC_sptbr_type'($urandom_range(2, 1)),
          $urandom_range(1) == 1, $urandom_range(99) < 30, $urandom_range(99) < 40,
          2'($urandom_range(3)), $urandom_range(99) < 10, $urandom_range(99) < 10,
          $urandom_range(99) < 3);
    end
    @(negedge clk);
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
